// File: rtl/ecc_stream_encoder.sv
// Streaming Hamming ECC encoder.
// Folds WORDS input beats of DATA_WIDTH bits into a syndrome/parity accumulator
// and presents one {overall parity, syndrome} code per block on a held output.
// The next block can stream in while the previous code waits to be accepted.
module ecc_stream_encoder #(
  parameter int DATA_WIDTH = 16,
  parameter int WORDS      = 8,
  localparam int N         = WORDS * DATA_WIDTH,
  localparam int SYN_W     = $clog2(N + 1),
  localparam int CNT_W     = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SYN_W:0]        out_code,
  output logic [CNT_W-1:0]      beat_cnt
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

  // Code contribution of one beat: syndrome is the XOR of (k+1) over every set
  // bit k of the block, parity is the XOR of the bits themselves.
  function automatic logic [SYN_W:0] beat_contrib(input logic [DATA_WIDTH-1:0] d,
                                                  input logic [CNT_W-1:0]      w);
    logic [SYN_W-1:0] syn;
    logic [SYN_W-1:0] base;
    logic             par;
    syn  = '0;
    par  = 1'b0;
    base = SYN_W'(w) * SYN_W'(DATA_WIDTH);
    for (int b = 0; b < DATA_WIDTH; b++) begin
      if (d[b]) begin
        syn = syn ^ (base + SYN_W'(b + 1));
        par = ~par;
      end
    end
    return {par, syn};
  endfunction

  logic [SYN_W:0]   acc_q, acc_d;
  logic [SYN_W:0]   out_code_q, out_code_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [SYN_W:0]   contrib;
  logic             last_beat;
  logic             accept;

  assign last_beat = (beat_cnt_q == LAST_BEAT);
  // The final beat is held off while a code is still pending, so a new code
  // never overwrites an unaccepted one; rst_n gating keeps ready low in reset.
  assign in_ready  = rst_n && enable && !clr && !(out_valid_q && last_beat);
  assign accept    = in_valid && in_ready;
  assign contrib   = beat_contrib(in_data, beat_cnt_q);

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign beat_cnt  = beat_cnt_q;

  // Next-state: accumulate accepted beats, close the block on the last beat,
  // abort on clr, and drop out_valid when the pending code is taken.
  always_comb begin
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    out_code_d  = out_code_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      acc_d      = '0;
      beat_cnt_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        acc_d      = '0;
        beat_cnt_d = '0;
      end else begin
        acc_d      = acc_q ^ contrib;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
    if (accept && last_beat) begin
      out_code_d  = acc_q ^ contrib;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any partial block and pending code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
